// File: rtl/fifo_uart_tx.sv
// FIFO read-side drain: pops one byte per frame and serialises it as 8N1 UART on tx.
// Define FIFO_UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8
) (
  input  logic              clk_r,
  input  logic              rst,
  input  logic              tx_en,
  input  logic              buf_empty,
  input  logic [DATA_W-1:0] buf_out,
  output logic              rd_en,
  output logic              tx,
  output logic              tx_busy,
  output logic [15:0]       tx_count
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(DATA_W - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [15:0]       count_q, count_d;
  logic              tx_q, tx_d;
  logic              rd_en_q, rd_en_d;
  logic              busy_q, busy_d;
  logic              bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    count_d = count_q;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (tx_en && !buf_empty) state_d = FETCH;
      end
      FETCH: begin
        baud_d  = '0;
        state_d = LOAD;
      end
      // The FIFO presents the popped byte one cycle after rd_en, so it is captured here.
      LOAD: begin
        baud_d  = '0;
        bit_d   = '0;
        shift_d = buf_out;
`ifdef FIFO_UART_TX_PARITY_EN
        parity_d = ^buf_out;
`endif
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef FIFO_UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
`endif
      // tx_en and buf_empty are only consulted here, so mid-frame changes never truncate a frame.
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          count_d = count_q + 16'd1;
          state_d = (tx_en && !buf_empty) ? FETCH : IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    rd_en_d = (state_d == FETCH);
    busy_d  = (state_d != IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_d = parity_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      count_q <= '0;
      tx_q    <= 1'b1;
      rd_en_q <= 1'b0;
      busy_q  <= 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      count_q <= count_d;
      tx_q    <= tx_d;
      rd_en_q <= rd_en_d;
      busy_q  <= busy_d;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx       = tx_q;
  assign rd_en    = rd_en_q;
  assign tx_busy  = busy_q;
  assign tx_count = count_q;

endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side drain stage for the dual-clock byte FIFO. Runs in the FIFO read clock domain, pops one byte at a time through the FIFO read port and serialises each byte as an 8N1 UART frame on a single output line. Sits directly downstream of the FIFO and connects to its buf_empty, rd_en and buf_out signals.

Parameters:
CLKS_PER_BIT, 16, clk_r cycles per UART bit; legal range 2..65535; 16 for simulation, 868 for 100 MHz / 115200 baud.
DATA_W, 8, bits per frame payload; fixed at 8 to match the FIFO width.

Ports:
clk_r  input  1  FIFO read-domain clock; all state updates on its rising edge.
rst  input  1  asynchronous, active-high reset.
tx_en  input  1  permits new frames to start; sampled only at frame boundaries.
buf_empty  input  1  FIFO empty flag.
buf_out  input  8  FIFO read data.
rd_en  output  1  FIFO pop strobe; one cycle per byte.
tx  output  1  serial line; idles high; registered output.
tx_busy  output  1  high in every state except IDLE.
tx_count  output  16  count of frames fully sent.

Behaviour:
- Reset values, applied asynchronously and held while rst=1:
  - tx=1, rd_en=0, tx_busy=0, tx_count=0
  - state=IDLE, baud counter=0, bit index=0, shift register=0
- States and transitions:
  - IDLE: if tx_en=1 and buf_empty=0, go to FETCH.
  - FETCH: exactly 1 cycle; rd_en=1. Go to LOAD.
  - LOAD: exactly 1 cycle; rd_en=0; shift register <= buf_out. The FIFO presents the popped byte on buf_out the cycle after rd_en. Go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits sent LSB first, each held CLKS_PER_BIT cycles. The shift register moves right at each bit end.
  - STOP: tx=1 for CLKS_PER_BIT cycles. At its final cycle, tx_count increments.
  - After STOP: go to FETCH if tx_en=1 and buf_empty=0, otherwise go to IDLE.
- Baud counter:
  - Runs 0..CLKS_PER_BIT-1 and reloads to 0 at each bit boundary.
  - Held at 0 in IDLE, FETCH and LOAD.
- Timing:
  - Frame length is 10*CLKS_PER_BIT cycles.
  - Back-to-back frames are separated by exactly 2 idle-high cycles (FETCH, LOAD).
  - From IDLE with data available, the first rd_en occurs 1 cycle after buf_empty falls. The start bit begins 2 cycles after rd_en.
- rd_en is asserted only from FETCH. The block never pops while buf_empty=1, so FIFO underflow is impossible.
- tx_en:
  - Deasserting it mid-frame does not truncate the frame; the frame completes.
  - After the frame, no further FETCH occurs until tx_en=1.
- buf_empty changes mid-frame are ignored until the STOP decision point.
- tx_count wraps from 0xFFFF to 0x0000.
- Reset mid-frame: tx returns to 1 immediately and the in-flight byte is lost (it was already popped from the FIFO). After release, the block restarts from IDLE.

Optional Feature:
Macro: FIFO_UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives the even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - Frame length becomes 11*CLKS_PER_BIT; the 2-cycle inter-frame gap is unchanged.
- Undefined: no PARITY state exists, the parity logic is absent, and frames are 8N1.

Test Plan:
1. Reset with CLKS_PER_BIT=16: assert rst, hold buf_empty=1 for 50 cycles -> tx=1, rd_en=0, tx_busy=0, tx_count=0 throughout.
2. Single byte 0x32 (tx_en=1, buf_empty falls) -> one rd_en pulse, then:
   - tx low for 16 cycles (start bit)
   - data bits 0,1,0,0,1,1,0,0 at 16 cycles each
   - 16 cycles high (stop bit)
   - frame of 160 cycles; tx_count=1; tx_busy falls after stop.
3. Back-to-back 0x32, 0x1D, 0x3D queued -> three rd_en pulses 162 cycles apart and 2-cycle high gaps between frames. Decoded bytes on tx are 0x32, 0x1D, 0x3D; tx_count=3.
4. Drop tx_en during data bit 3 with bytes still queued -> the current frame completes with correct bits, and no rd_en occurs. Raising tx_en gives rd_en on the next cycle.
5. Assert rst during data bit 5 of 0xFF -> tx=1 in the same cycle, tx_count=0, rd_en=0. After release with data queued, a full correct frame follows.
6. With FIFO_UART_TX_PARITY_EN defined:
   - 0x32 gives parity bit 1 and 0x1D gives parity bit 0.
   - Each frame is 176 cycles; tx_count increments per frame.
